// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and the injection-arbiter state encoding.
// Imported by the arbiter and by its round-robin picker.
package noc_pkg;

    localparam int NOC_DATA_WIDTH = 32;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
// Ports: i_req (requests), i_ptr (last winner); o_any (any request), o_idx (winner).
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_any,
    output logic [ID_W-1:0] o_idx
);

    // Scan from the farthest offset down so the nearest one after i_ptr wins.
    always_comb begin
        int             w_pos;
        logic [ID_W-1:0] w_j;
        o_any = 1'b0;
        o_idx = '0;
        w_pos = 0;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_pos = (int'(i_ptr) + k) % N;
            w_j   = ID_W'(w_pos);
            if (i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
    end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router local injection port.
// Ports: noc_clk/noc_rst, req_* (per-source flits), out_* (to router), grant_id/busy/proto_err.
module noc_local_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int DATA_W = NOC_DATA_WIDTH
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_flit,
    input  logic [N_REQ-1:0]        req_is_header,
    input  logic [N_REQ-1:0]        req_is_tail,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_flit,
    output logic                    out_is_header,
    output logic                    out_is_tail,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    proto_err
);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_grant;
    logic            r_perr;

    logic            w_lock;
    logic            w_any;
    logic [ID_W-1:0] w_idx;
    logic            w_bad;
    logic            w_done;

    assign w_lock = (r_state == ARB_LOCK);
    assign w_bad  = |(req_valid & ~req_is_header);

    noc_rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .i_req (req_valid & req_is_header),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Outputs toward the router depend only on state and req_*, never on out_ready.
    assign out_valid     = w_lock & req_valid[r_grant];
    assign out_flit      = req_flit[r_grant*DATA_W +: DATA_W];
    assign out_is_header = req_is_header[r_grant];
    assign out_is_tail   = req_is_tail[r_grant];

    always_comb begin
        req_ready = '0;
        if (w_lock) begin
            req_ready[r_grant] = out_ready;
        end
    end

    assign w_done = out_valid & out_ready & out_is_tail;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= ID_W'(N_REQ - 1);
            r_grant <= '0;
            r_perr  <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_bad) begin
                        r_perr <= 1'b1;
                    end
                    if (w_any) begin
                        r_state <= ARB_LOCK;
                        r_grant <= w_idx;
                    end
                end
                ARB_LOCK: begin
                    // Pointer moves only at packet end; next arbitration is a cycle later.
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                        r_ptr   <= r_grant;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign busy      = w_lock;
    assign grant_id  = r_grant;
    assign proto_err = r_perr;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Randomized bench for noc_local_inject_arbiter against a packet-level model.
// Sources generate numbered packets; the model predicts every output each cycle.
module tb_noc_local_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rv, rh, rt, rr;
    logic [N*DW-1:0] rf;
    logic            ov, ordy, oh, ot;
    logic [DW-1:0]   of;
    logic [1:0]      gid;
    logic            bsy, perr;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: owner of the port (-1 when free), last winner, sticky error
    int m_owner, m_ptr, m_grant;
    bit m_perr;

    // source state
    bit src_on  [N];
    int src_len [N];
    int src_idx [N];
    int src_pkt [N];

    // phase configuration
    logic [N-1:0] cfg_mask;
    int cfg_len, cfg_fixed, cfg_vpct, cfg_rmode, cfg_rst_pct, cfg_bad;

    noc_local_inject_arbiter dut (
        .noc_clk       (clk),
        .noc_rst       (rst),
        .req_valid     (rv),
        .req_ready     (rr),
        .req_flit      (rf),
        .req_is_header (rh),
        .req_is_tail   (rt),
        .out_valid     (ov),
        .out_ready     (ordy),
        .out_flit      (of),
        .out_is_header (oh),
        .out_is_tail   (ot),
        .grant_id      (gid),
        .busy          (bsy),
        .proto_err     (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_grant = 0;
        m_perr  = 1'b0;
        for (int i = 0; i < N; i++) src_on[i] = 1'b0;
    endtask

    task automatic drive();
        rst = (cfg_rst_pct > 0) && ($urandom_range(99) < cfg_rst_pct);
        case (cfg_rmode)
            0:       ordy = 1'b1;
            1:       ordy = ~ordy;
            default: ordy = 1'($urandom_range(1));
        endcase
        for (int i = 0; i < N; i++) begin
            if (!src_on[i] && cfg_mask[i] && cfg_bad != i) begin
                src_on[i]  = 1'b1;
                src_len[i] = cfg_fixed ? cfg_len : int'($urandom_range(cfg_len, 1));
                src_idx[i] = 0;
                src_pkt[i] = src_pkt[i] + 1;
            end
            if (cfg_bad == i) begin
                rv[i] = 1'b1;
                rh[i] = 1'b0;
                rt[i] = 1'b0;
                rf[i*DW +: DW] = 32'h0BAD_0000 | i;
            end else begin
                rv[i] = src_on[i] && ($urandom_range(99) < cfg_vpct);
                rh[i] = (src_idx[i] == 0);
                rt[i] = (src_idx[i] == src_len[i] - 1);
                rf[i*DW +: DW] = {8'(i), 8'(src_pkt[i]), 16'(src_idx[i])};
            end
        end
    endtask

    task automatic check_and_step();
        logic [N-1:0] e_rdy;
        bit           e_ov;
        e_ov  = (m_owner >= 0) && rv[m_owner];
        e_rdy = '0;
        if (m_owner >= 0 && ordy) e_rdy[m_owner] = 1'b1;
        chk("busy",      bsy,  m_owner >= 0);
        chk("grant_id",  gid,  m_grant);
        chk("proto_err", perr, m_perr);
        chk("req_ready", rr,   e_rdy);
        chk("out_valid", ov,   e_ov);
        if (e_ov) begin
            chk("out_flit",      of, rf[m_owner*DW +: DW]);
            chk("out_is_header", oh, rh[m_owner]);
            chk("out_is_tail",   ot, rt[m_owner]);
        end
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++)
                if (rv[i] && !rh[i]) m_perr = 1'b1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (rv[j] && rh[j]) begin
                    m_owner = j;
                    m_grant = j;
                    break;
                end
            end
        end else if (e_ov && ordy) begin
            src_idx[m_owner]++;
            if (rt[m_owner]) begin
                src_on[m_owner] = 1'b0;
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            drive();
            #1;
            check_and_step();
        end
    endtask

    task automatic cfg(input logic [N-1:0] mask, input int len, input int fixed,
                       input int vpct, input int rmode, input int rpct, input int bad);
        cfg_mask = mask; cfg_len = len; cfg_fixed = fixed; cfg_vpct = vpct;
        cfg_rmode = rmode; cfg_rst_pct = rpct; cfg_bad = bad;
    endtask

    initial begin
        rst  = 1'b1;
        ordy = 1'b0;
        rv = '0; rh = '0; rt = '0; rf = '0;
        for (int i = 0; i < N; i++) src_pkt[i] = 0;
        cfg(4'b0000, 1, 1, 100, 0, 0, -1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy",  bsy,  1'b0);
        chk("rst_grant", gid,  2'd0);
        chk("rst_perr",  perr, 1'b0);
        chk("rst_ov",    ov,   1'b0);
        chk("rst_rdy",   rr,   4'b0);

        // two 3-flit sources, ready always high
        cfg(4'b0101, 3, 1, 100, 0, 0, -1);
        run(40);
        // all sources, single-flit packets
        cfg(4'b1111, 1, 1, 100, 0, 0, -1);
        run(40);
        // src1 4-flit packets, out_ready toggling
        cfg(4'b0010, 4, 1, 100, 1, 0, -1);
        run(40);
        // src3/src0 with gappy valid
        cfg(4'b1001, 4, 1, 40, 0, 0, -1);
        run(80);
        // src2 offers non-header while idle, src1 normal
        cfg(4'b0010, 3, 0, 80, 2, 0, 2);
        run(60);
        chk("perr_sticky", perr, 1'b1);
        // reset clears the sticky error and the arbiter restarts at src0
        cfg(4'b1111, 5, 1, 100, 0, 100, -1);
        run(2);
        cfg(4'b1111, 5, 1, 100, 0, 0, -1);
        run(3);
        chk("post_rst_grant", gid, 2'd0);
        // everything random, occasional resets
        cfg(4'b1111, 5, 0, 70, 2, 2, -1);
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
